led_pattern_gen: RTL and testbench
==================================

Name: led_pattern_gen

Overview:
Parametrised LED pattern generator driving the board LED bank from the 27 MHz system clock. It steps a pattern register at a programmable rate and offers four selectable patterns: alternate-toggle, rotate, bounce and binary count. Global brightness is set by a free-running PWM duty. It replaces the fixed half-second toggle blinker as the board's status and heartbeat display.

Parameters:
NUM_LEDS, 6, LED count; legal range 2..32.
TICKS_PER_SECOND, 27_000_000, clk frequency in Hz.
STEPS_PER_SECOND, 2, pattern steps per second at speed=0.
ACTIVE_LOW, 1, 1 means nLed drives 0 to light an LED; 0 means active-high.
PWM_BITS, 4, width of the brightness duty and of the PWM counter.

Ports:
clk  in  1  system clock.
rst  in  1  asynchronous, active-high reset.
en  in  1  1 lets the step timer run; 0 freezes the timer and the pattern.
mode  in  2  0 alternate-toggle, 1 rotate-left, 2 bounce, 3 binary count.
speed  in  2  step period is divided by 2^speed.
duty  in  PWM_BITS  brightness: 0 = off, all-ones = fully on.
step  out  1  one-cycle pulse on each pattern step.
pattern  out  NUM_LEDS  current logical pattern, active-high, registered.
nLed  out  NUM_LEDS  pad drive after PWM and polarity, registered.

Behaviour:
- Reset values (asynchronous on rst rising, no clock edge needed):
  - cnt = 0, step = 0, pwm_cnt = 0, dir = up, applied_mode = 0.
  - pattern = mode-0 seed.
  - nLed = all LEDs off: all ones when ACTIVE_LOW = 1, all zeros otherwise.
- Step period P = (TICKS_PER_SECOND / STEPS_PER_SECOND) >> speed, integer division. If the result is below 1, P = 1.
- Step timer, when en = 1:
  - If cnt >= P-1: cnt <= 0 and step <= 1.
  - Otherwise: cnt <= cnt+1 and step <= 0.
  - The >= comparison covers a speed increase mid-count; the step fires on the next cycle.
- When en = 0: cnt and pattern hold, and step = 0. PWM and nLed keep updating.
- Step width: 32-bit cnt, sufficient for any P.
- Seeds:
  - mode 0: alternating, bit0 = 1 (010101 for N = 6).
  - modes 1 and 2: one-hot bit0.
  - mode 3: all zeros.
- Pattern update occurs on the clock edge where the step condition is true, the same edge that registers step = 1.
  - If mode != applied_mode: pattern <= seed(mode), applied_mode <= mode, dir <= up. No advance on this step.
  - Otherwise the pattern advances as listed below.
  - Mode changes are therefore ignored until the next step.
- Advance rules:
  - mode 0: pattern <= ~pattern.
  - mode 1: rotate left; bit N-1 wraps to bit0.
  - mode 2, dir up: if bit N-1 is set, set dir = down and shift right; otherwise shift left.
  - mode 2, dir down: if bit0 is set, set dir = up and shift left; otherwise shift right.
  - mode 2 sequence has period 2N-2 and never holds an end position for two steps.
  - mode 3: pattern <= pattern + 1, modulo 2^N; all ones wraps to all zeros.
- PWM:
  - pwm_cnt increments every clk, wrapping modulo 2^PWM_BITS.
  - on = 1 if duty is all ones; otherwise on = (pwm_cnt < duty).
  - nLed[i] <= (pattern[i] & on) XOR ACTIVE_LOW, registered.
  - Latency from pattern or pwm_cnt to nLed is 1 clk.
- Rate: all rate arithmetic is elaborated from parameters. The only runtime arithmetic is the shift by speed and the comparisons.
- Reset mid-step: any partial count is discarded. After release, the first step occurs P cycles later.

Test Plan:
All scenarios use TICKS_PER_SECOND = 16, STEPS_PER_SECOND = 2 (P = 8), NUM_LEDS = 6, ACTIVE_LOW = 1, duty = 15, unless stated.
1. Basic toggle. Stimulus: release rst, en = 1, mode = 0, speed = 0. Required:
   - pattern = 010101 after reset.
   - step pulses on the 8th, 16th, ... rising edge after release.
   - pattern goes 101010, then 010101.
   - nLed = ~pattern, one clk after each change.
2. Mode seeding and wraps:
   - mode = 1: first step loads 000001; the next steps give 000010 ... 100000, then 000001.
   - mode = 3, forced to 111111: the next step gives 000000.
3. Bounce. Stimulus: NUM_LEDS = 4, mode = 2. Required: after seeding, the sequence is 0001, 0010, 0100, 1000, 0100, 0010, 0001, 0010.
4. Speed and enable:
   - speed = 3 (P = 1): step every cycle.
   - Change speed 0 to 1 with cnt = 5: step on the next edge.
   - en = 0 for 20 cycles: no step, and pattern unchanged.
5. PWM:
   - duty = 4 with pattern bit set: that nLed is low for exactly 4 of every 16 cycles.
   - duty = 0: nLed = 111111 constantly.
   - duty = 15: the lit bit is low continuously.
6. Asynchronous reset:
   - Assert rst between clock edges mid-count, with mode 1 applied: nLed goes to 111111 and step to 0 before the next edge.
   - After release, pattern is 010101, and the first step occurs 8 cycles later, loading the mode-1 seed.

Source files
------------

// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Board LED bank driver: steps a pattern register at a programmable rate,
//   offers four patterns (alternate-toggle, rotate-left, bounce, binary count)
//   and dims the whole bank with a free-running PWM.
//
// Ports
//   i_clk      system clock
//   i_rst      asynchronous, active-high reset
//   i_en       1 runs the step timer, 0 freezes timer and pattern
//   i_mode     0 toggle, 1 rotate-left, 2 bounce, 3 binary count
//   i_speed    step period is divided by 2^speed
//   i_duty     brightness, 0 = off, all-ones = fully on
//   o_step     one-cycle pulse on each pattern step
//   o_pattern  logical pattern, active-high, registered
//   o_nled     pad drive after PWM and polarity, registered
//
// Bounce direction
//   state    | meaning
//   DIR_UP   | lit bit moves toward bit NUM_LEDS-1
//   DIR_DOWN | lit bit moves toward bit 0
module led_pattern_gen #(
  parameter int NUM_LEDS         = 6,
  parameter int TICKS_PER_SECOND = 27_000_000,
  parameter int STEPS_PER_SECOND = 2,
  parameter int ACTIVE_LOW       = 1,
  parameter int PWM_BITS         = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_en,
  input  logic [1:0]          i_mode,
  input  logic [1:0]          i_speed,
  input  logic [PWM_BITS-1:0] i_duty,
  output logic                o_step,
  output logic [NUM_LEDS-1:0] o_pattern,
  output logic [NUM_LEDS-1:0] o_nled
);

  localparam logic [31:0] BASE_PERIOD = 32'(TICKS_PER_SECOND / STEPS_PER_SECOND);
  localparam logic [NUM_LEDS-1:0] LEDS_OFF =
    (ACTIVE_LOW != 0) ? {NUM_LEDS{1'b1}} : {NUM_LEDS{1'b0}};

  typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

  function automatic logic [NUM_LEDS-1:0] seed(input logic [1:0] mode);
    logic [NUM_LEDS-1:0] s;
    s = '0;
    case (mode)
      2'd0: for (int i = 0; i < NUM_LEDS; i += 2) s[i] = 1'b1;
      2'd1, 2'd2: s[0] = 1'b1;
      default: s = '0;
    endcase
    return s;
  endfunction

  logic [31:0]         r_cnt;
  logic                r_step;
  logic [NUM_LEDS-1:0] r_pattern;
  logic [NUM_LEDS-1:0] r_nled;
  logic [PWM_BITS-1:0] r_pwm_cnt;
  logic [1:0]          r_applied_mode;
  dir_t                r_dir;

  logic [31:0]         w_shifted;
  logic [31:0]         w_period;
  logic                w_fire;
  logic [NUM_LEDS-1:0] w_adv_pattern;
  dir_t                w_adv_dir;
  logic                w_on;
  logic [NUM_LEDS-1:0] w_nled_next;

  // Only the shift by speed is done at runtime; the base period is elaborated.
  assign w_shifted = BASE_PERIOD >> i_speed;
  assign w_period  = (w_shifted == 32'd0) ? 32'd1 : w_shifted;
  // >= rather than == so a mid-count speed-up fires on the next edge.
  assign w_fire    = i_en && (r_cnt >= (w_period - 32'd1));

  always_comb begin
    w_adv_pattern = r_pattern;
    w_adv_dir     = r_dir;
    case (r_applied_mode)
      2'd0: w_adv_pattern = ~r_pattern;
      2'd1: w_adv_pattern = {r_pattern[NUM_LEDS-2:0], r_pattern[NUM_LEDS-1]};
      2'd2: begin
        // Reverse at the end and move in the same step, so no end is held twice.
        if (r_dir == DIR_UP) begin
          if (r_pattern[NUM_LEDS-1]) begin
            w_adv_dir     = DIR_DOWN;
            w_adv_pattern = r_pattern >> 1;
          end else begin
            w_adv_pattern = r_pattern << 1;
          end
        end else begin
          if (r_pattern[0]) begin
            w_adv_dir     = DIR_UP;
            w_adv_pattern = r_pattern << 1;
          end else begin
            w_adv_pattern = r_pattern >> 1;
          end
        end
      end
      default: w_adv_pattern = r_pattern + NUM_LEDS'(1);
    endcase
  end

  // All-ones duty is forced fully on; the compare alone would leave one dark slot.
  assign w_on        = (&i_duty) | (r_pwm_cnt < i_duty);
  assign w_nled_next = (r_pattern & {NUM_LEDS{w_on}}) ^ LEDS_OFF;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt          <= '0;
      r_step         <= 1'b0;
      r_pattern      <= seed(2'd0);
      r_nled         <= LEDS_OFF;
      r_pwm_cnt      <= '0;
      r_applied_mode <= 2'd0;
      r_dir          <= DIR_UP;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + PWM_BITS'(1);
      r_nled    <= w_nled_next;
      if (w_fire) begin
        r_cnt  <= '0;
        r_step <= 1'b1;
        // A new mode only takes effect at a step, and that step just seeds it.
        if (i_mode != r_applied_mode) begin
          r_pattern      <= seed(i_mode);
          r_applied_mode <= i_mode;
          r_dir          <= DIR_UP;
        end else begin
          r_pattern <= w_adv_pattern;
          r_dir     <= w_adv_dir;
        end
      end else begin
        r_step <= 1'b0;
        if (i_en) r_cnt <= r_cnt + 32'd1;
      end
    end
  end

  assign o_step    = r_step;
  assign o_pattern = r_pattern;
  assign o_nled    = r_nled;

endmodule

// File: tb/tb_led_pattern_gen.sv
module tb_led_pattern_gen;

  localparam int N = 6;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [1:0] mode;
  logic [1:0] speed;
  logic [3:0] duty;
  logic       o_step;
  logic [N-1:0] o_pattern;
  logic [N-1:0] o_nled;

  logic       b_en;
  logic [1:0] b_mode;
  logic [1:0] b_speed;
  logic [3:0] b_duty;
  logic       b_step;
  logic [3:0] b_pattern;
  logic [3:0] b_nled;

  int errors = 0;
  int checks = 0;

  // Reference model: pattern derived from (applied mode, steps since seeding).
  int       m_mode;
  int       m_idx;
  int       m_cnt;
  int       m_pwm;
  logic     m_step;
  logic [N-1:0] m_nled;

  always #5 clk = ~clk;

  led_pattern_gen #(
    .NUM_LEDS(N), .TICKS_PER_SECOND(16), .STEPS_PER_SECOND(2),
    .ACTIVE_LOW(1), .PWM_BITS(4)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_mode(mode), .i_speed(speed),
    .i_duty(duty), .o_step(o_step), .o_pattern(o_pattern), .o_nled(o_nled)
  );

  led_pattern_gen #(
    .NUM_LEDS(4), .TICKS_PER_SECOND(16), .STEPS_PER_SECOND(2),
    .ACTIVE_LOW(1), .PWM_BITS(4)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(b_en), .i_mode(b_mode), .i_speed(b_speed),
    .i_duty(b_duty), .o_step(b_step), .o_pattern(b_pattern), .o_nled(b_nled)
  );

  function automatic logic [N-1:0] exp_pat(input int md, input int idx);
    int k;
    int pos;
    case (md)
      0: return (idx % 2 == 0) ? 6'b010101 : 6'b101010;
      1: return N'(1 << (idx % N));
      2: begin
        k   = idx % (2 * N - 2);
        pos = (k < N) ? k : (2 * N - 2 - k);
        return N'(1 << pos);
      end
      default: return N'(idx % (1 << N));
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_idx  = 0;
    m_cnt  = 0;
    m_pwm  = 0;
    m_step = 1'b0;
    m_nled = '1;
  endtask

  task automatic tick();
    logic [N-1:0] cur;
    int  p;
    bit  fire;
    bit  on;
    @(posedge clk);
    cur    = exp_pat(m_mode, m_idx);
    on     = (duty == 4'hF) ? 1'b1 : (m_pwm < int'(duty));
    m_nled = on ? ~cur : '1;
    m_pwm  = (m_pwm + 1) % 16;
    p      = 8 >> speed;
    if (p < 1) p = 1;
    fire   = en && (m_cnt >= p - 1);
    if (en) m_cnt = fire ? 0 : m_cnt + 1;
    m_step = fire;
    if (fire) begin
      if (int'(mode) != m_mode) begin
        m_mode = int'(mode);
        m_idx  = 0;
      end else begin
        m_idx++;
      end
    end
    #1;
    check("step", 32'(o_step), 32'(m_step));
    check("pattern", 32'(o_pattern), 32'(exp_pat(m_mode, m_idx)));
    check("nled", 32'(o_nled), 32'(m_nled));
  endtask

  initial begin
    logic [N-1:0] hold;
    logic [3:0]   bounce_exp [8];
    int lows;

    bounce_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b0010};
    rst = 1'b1; en = 1'b0; mode = 2'd0; speed = 2'd0; duty = 4'hF;
    b_en = 1'b0; b_mode = 2'd2; b_speed = 2'd3; b_duty = 4'hF;
    #2;
    check("reset_pattern", 32'(o_pattern), 32'(6'b010101));
    check("reset_nled", 32'(o_nled), 32'(6'b111111));
    check("reset_step", 32'(o_step), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Bounce on a 4-LED instance, one step per cycle.
    b_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("bounce", 32'(b_pattern), 32'(bounce_exp[i]));
    end
    b_en = 1'b0;

    // Basic toggle at P = 8.
    en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      tick();
      if (i == 7) check("toggle_no_step_early", 32'(o_step), 32'd0);
      if (i == 8) begin
        check("toggle_step8", 32'(o_step), 32'd1);
        check("toggle_pat8", 32'(o_pattern), 32'(6'b101010));
      end
      if (i == 9) check("toggle_nled9", 32'(o_nled), 32'(6'b010101));
      if (i == 16) check("toggle_pat16", 32'(o_pattern), 32'(6'b010101));
    end

    // Speed-up mid-count: cnt = 5, then P drops to 4.
    for (int i = 0; i < 5; i++) tick();
    speed = 2'd1;
    tick();
    check("speedup_step", 32'(o_step), 32'd1);
    speed = 2'd0;

    // Enable low freezes everything but PWM.
    en = 1'b0;
    hold = o_pattern;
    for (int i = 0; i < 20; i++) begin
      tick();
      check("frozen_step", 32'(o_step), 32'd0);
      check("frozen_pattern", 32'(o_pattern), 32'(hold));
    end
    en = 1'b1;

    // Rotate with wrap, one step per cycle.
    mode = 2'd1; speed = 2'd3;
    for (int i = 0; i < 7; i++) begin
      tick();
      check("rotate", 32'(o_pattern), 32'(6'b1 << (i % 6)));
    end

    // Binary count wraps 111111 -> 000000.
    mode = 2'd3;
    tick();
    check("count_seed", 32'(o_pattern), 32'd0);
    for (int i = 0; i < 63; i++) tick();
    check("count_full", 32'(o_pattern), 32'(6'b111111));
    tick();
    check("count_wrap", 32'(o_pattern), 32'd0);

    // PWM with bit 0 lit and the pattern frozen.
    mode = 2'd1;
    tick();
    en = 1'b0;
    duty = 4'd4;
    tick();
    lows = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (o_nled[0] == 1'b0) lows++;
    end
    check("pwm_duty4_lows", 32'(lows), 32'd4);
    duty = 4'd0;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("pwm_duty0", 32'(o_nled), 32'(6'b111111));
    end
    duty = 4'd15;
    for (int i = 0; i < 16; i++) begin
      tick();
      check("pwm_duty15", 32'(o_nled[0]), 32'd0);
    end

    // Asynchronous reset mid-count with mode 1 applied.
    en = 1'b1; speed = 2'd0;
    for (int i = 0; i < 3; i++) tick();
    #3 rst = 1'b1;
    #1;
    check("arst_nled", 32'(o_nled), 32'(6'b111111));
    check("arst_step", 32'(o_step), 32'd0);
    check("arst_pattern", 32'(o_pattern), 32'(6'b010101));
    #1 rst = 1'b0;
    model_reset();
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (i == 8) begin
        check("arst_first_step", 32'(o_step), 32'd1);
        check("arst_seed", 32'(o_pattern), 32'(6'b000001));
      end
    end

    // Randomized segments against the model.
    for (int s = 0; s < 40; s++) begin
      mode  = 2'($urandom_range(0, 3));
      speed = 2'($urandom_range(0, 3));
      en    = ($urandom_range(0, 4) != 0);
      duty  = 4'($urandom_range(0, 15));
      for (int i = 0; i < int'($urandom_range(1, 30)); i++) tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
